ck2ck_fifo_wr_ctrl: RTL and testbench
=====================================

Name: ck2ck_fifo_wr_ctrl

Overview:
- Write-side controller of the dual-clock FIFO family, living entirely in the ckFast domain.
- Accepts push data via a valid/ready handshake and drives the FIFO storage write port.
- Publishes a Gray-coded write pointer to the read side and synchronises the read side's Gray pointer back into ckFast.
- Generates full, almost-full, fill level and overflow indication; pairs with the ckSlow-domain read controller.

Parameters:
- DATA_W, 8, width of each FIFO word.
- ADDR_W, 4, storage address width; depth = 2**ADDR_W (16).
- SYNC_STAGES, 2, flip-flop stages in the read-pointer synchroniser; legal range 2..4.
- AFULL_TH, 12, almostFull asserts when level >= AFULL_TH; legal range 1..2**ADDR_W.

Ports:
- ckFast  in  1  write-domain clock.
- arstFast  in  1  reset: asynchronous, active-high.
- pushValid  in  1  producer has a word on pushData.
- pushData  in  DATA_W  word to write.
- pushReady  out  1  controller can accept a word this cycle.
- memWrEna  out  1  storage write strobe, combinational = pushValid & pushReady.
- memWrAddr  out  ADDR_W  storage write address = wrBin[ADDR_W-1:0].
- memWrData  out  DATA_W  = pushData (pass-through).
- wrPtrGray  out  ADDR_W+1  registered Gray write pointer, to the read domain.
- rdPtrGrayAsync  in  ADDR_W+1  Gray read pointer from ckSlow; asynchronous to ckFast.
- full  out  1  registered; FIFO holds 2**ADDR_W words.
- almostFull  out  1  registered; level >= AFULL_TH.
- level  out  ADDR_W+1  registered; wrBin minus synchronised rdBin, modulo 2**(ADDR_W+1).
- overflowErr  out  1  one-cycle pulse when pushValid is high while full is high.

Behaviour:
- Reset (arstFast high):
  - wrBin, wrPtrGray, sync stages, level = 0; full = 0; almostFull = 0; overflowErr = 0.
  - pushReady = 0; FSM enters ST_INIT.
- FSM type ty_Ck2CkFifoWrStates, states ST_INIT, ST_RUN, ST_FULL. Current state registered; next state combinational.
- ST_INIT:
  - init counter counts SYNC_STAGES+1 cycles after reset release; pushReady = 0.
  - Goes to ST_RUN when the counter reaches terminal.
  - Purpose: flush stale synchroniser contents.
- ST_RUN:
  - pushReady = 1.
  - Accepted push (pushValid & pushReady at a posedge): storage written at that edge; wrBin += 1 and wrPtrGray = bin2gray(wrBin+1) at the same edge.
  - Data is therefore in storage before the pointer is visible to the read side.
  - Goes to ST_FULL when the next-pointer full test is true.
- ST_FULL:
  - pushReady = 0; full = 1.
  - Returns to ST_RUN the first cycle the synchronised read pointer shows free space.
- Full test: Gray write pointer equals the synchronised read Gray pointer with its top two bits inverted. It is evaluated on the post-push pointer, so full asserts on the edge that writes the 2**ADDR_W-th word; there are no extra-cycle overwrites.
- Level:
  - gray2bin(rdSync) subtracted from wrBin in ADDR_W+1 bit arithmetic; the wrap of the extra MSB is intentional.
  - Registered, 1-cycle latency after a pointer change.
  - Pessimistic: it may over-report by the synchroniser latency, never under-report.
- Read-pointer latency: a read-side pointer change appears in full/level after SYNC_STAGES+1 ckFast edges.
- Pointer wrap: wrBin wraps from 2**(ADDR_W+1)-1 to 0; full and level stay correct across the wrap.
- Simultaneous push and read-pointer advance while full: the push is refused (pushReady was 0). Space is seen only via the synchronised pointer.
- Push while full: word dropped; overflowErr pulses for every such cycle; wrBin unchanged.
- Reset mid-operation: all state clears immediately (asynchronous). The read side must be reset concurrently; no partial-word recovery.

Optional Feature:
- CK2CK_WR_OVF_CNT_EN defined:
  - Adds output ovfCount (16 bits), reset 0.
  - Increments on each overflowErr cycle and saturates at 16'hFFFF.
  - Adds input ovfClr (1 bit), which synchronously zeroes the count; clear wins over a same-cycle increment.
- Macro undefined: ovfCount and ovfClr do not exist; overflowErr alone reports drops.

Decomposition:
- Package ck2ck_fifo_pkg:
  - ty_Ck2CkFifoWrStates enum.
  - bin2gray and gray2bin functions, parameterised via width argument.
  - Default DATA_W/ADDR_W localparams, shared with the read controller.
- Sub-module ck2ck_sync_bus: SYNC_STAGES-deep flip-flop chain over a bus, reset to 0. Instantiated once here for rdPtrGrayAsync and reused by the read controller.

Test Plan:
- Release reset with pushValid=1 -> pushReady=0 for exactly SYNC_STAGES+1 = 3 cycles, then 1; no memWrEna during INIT.
- Hold read pointer at 0 and push 16 words 8'h00..8'h0F -> memWrAddr 0..15; full=1 after the 16th edge; level=16; almostFull rises when level=12; wrPtrGray=5'b11000.
- While full, hold pushValid for 3 cycles -> 3 overflowErr pulses; wrBin unchanged; with CK2CK_WR_OVF_CNT_EN, ovfCount=3, and ovfClr returns it to 0.
- From full, advance rdPtrGrayAsync to gray(1) -> full drops after 3 ckFast edges; level=15; one further push is accepted at addr 0.
- Stream 40 words with the read pointer tracking 4 words behind -> wrBin wraps past 31; level stays 4..7; full never asserts.
- Assert arstFast mid-stream at level=9 -> all outputs 0 immediately, FSM back to ST_INIT, and the INIT sequence repeats.

Source files
------------

// File: rtl/ck2ck_fifo_pkg.sv
// Shared types and pointer helpers for the dual-clock FIFO controllers.
// Default widths here are common to the write and read sides.
package ck2ck_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } ty_Ck2CkFifoWrStates;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
    logic [31:0] b;
    b = bin & ((32'h1 << width) - 32'h1);
    return b ^ (b >> 1);
  endfunction

  // Bits above width are masked to zero, so the MSB-down XOR chain is exact.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] g;
    logic [31:0] b;
    g = gray & ((32'h1 << width) - 32'h1);
    b = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ck2ck_sync_bus.sv
// Multi-stage flip-flop synchroniser over a Gray-coded bus, cleared by reset.
module ck2ck_sync_bus #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             ck,
  input  logic             arst,
  input  logic [WIDTH-1:0] bus_async,
  output logic [WIDTH-1:0] bus_sync
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= bus_async;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bus_sync = stage_q[STAGES-1];

endmodule

// File: rtl/ck2ck_fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO (ckFast domain).
// Define CK2CK_WR_OVF_CNT_EN to add the saturating ovfCount / ovfClr pair.
module ck2ck_fifo_wr_ctrl
  import ck2ck_fifo_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 12
) (
  input  logic              ckFast,
  input  logic              arstFast,
  input  logic              pushValid,
  input  logic [DATA_W-1:0] pushData,
  output logic              pushReady,
  output logic              memWrEna,
  output logic [ADDR_W-1:0] memWrAddr,
  output logic [DATA_W-1:0] memWrData,
  output logic [ADDR_W:0]   wrPtrGray,
  input  logic [ADDR_W:0]   rdPtrGrayAsync,
  output logic              full,
  output logic              almostFull,
  output logic [ADDR_W:0]   level,
`ifdef CK2CK_WR_OVF_CNT_EN
  input  logic              ovfClr,
  output logic [15:0]       ovfCount,
`endif
  output logic              overflowErr
);

  localparam int               PTR_W     = ADDR_W + 1;
  localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

  ty_Ck2CkFifoWrStates state, next_state;
  logic [2:0]       init_cnt;
  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] wr_bin_next;
  logic [PTR_W-1:0] wr_gray_next;
  logic [PTR_W-1:0] rd_sync;
  logic [PTR_W-1:0] rd_bin_sync;
  logic [PTR_W-1:0] full_gray;
  logic [PTR_W-1:0] level_next;
  logic             full_test;

  ck2ck_sync_bus #(
    .WIDTH (PTR_W),
    .STAGES(SYNC_STAGES)
  ) u_rd_sync (
    .ck       (ckFast),
    .arst     (arstFast),
    .bus_async(rdPtrGrayAsync),
    .bus_sync (rd_sync)
  );

  assign memWrEna  = pushValid & pushReady;
  assign memWrAddr = wr_bin[ADDR_W-1:0];
  assign memWrData = pushData;

  // Full and level are judged on the post-push pointer so the 2**ADDR_W-th
  // write raises full on its own edge and no later word can overwrite.
  assign wr_bin_next  = wr_bin + PTR_W'(memWrEna);
  assign wr_gray_next = PTR_W'(bin2gray(32'(wr_bin_next), PTR_W));
  assign rd_bin_sync  = PTR_W'(gray2bin(32'(rd_sync), PTR_W));
  assign full_gray    = {~rd_sync[PTR_W-1 -: 2], rd_sync[PTR_W-3:0]};
  assign full_test    = (wr_gray_next == full_gray);
  assign level_next   = wr_bin_next - rd_bin_sync;

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: if (init_cnt == INIT_LAST) next_state = ST_RUN;
      ST_RUN:  if (full_test) next_state = ST_FULL;
      ST_FULL: if (!full_test) next_state = ST_RUN;
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge ckFast or posedge arstFast) begin
    if (arstFast) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      wr_bin      <= '0;
      wrPtrGray   <= '0;
      pushReady   <= 1'b0;
      full        <= 1'b0;
      almostFull  <= 1'b0;
      level       <= '0;
      overflowErr <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_INIT && init_cnt != INIT_LAST) begin
        init_cnt <= init_cnt + 3'd1;
      end
      wr_bin      <= wr_bin_next;
      wrPtrGray   <= wr_gray_next;
      pushReady   <= (next_state == ST_RUN);
      full        <= (next_state == ST_FULL);
      level       <= level_next;
      almostFull  <= (level_next >= AFULL_LVL);
      overflowErr <= pushValid & full;
    end
  end

`ifdef CK2CK_WR_OVF_CNT_EN
  always_ff @(posedge ckFast or posedge arstFast) begin
    if (arstFast) begin
      ovfCount <= '0;
    end else if (ovfClr) begin
      ovfCount <= '0;
    end else if (overflowErr && ovfCount != 16'hFFFF) begin
      ovfCount <= ovfCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ck2ck_fifo_wr_ctrl.sv
// Self-checking bench for ck2ck_fifo_wr_ctrl: scoreboard on the storage write port
// plus per-scenario checks of handshake, full/level, overflow and reset.
module tb_ck2ck_fifo_wr_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              ckFast = 1'b0;
  logic              arstFast;
  logic              pushValid;
  logic [DATA_W-1:0] pushData;
  logic              pushReady;
  logic              memWrEna;
  logic [ADDR_W-1:0] memWrAddr;
  logic [DATA_W-1:0] memWrData;
  logic [ADDR_W:0]   wrPtrGray;
  logic [ADDR_W:0]   rdPtrGrayAsync;
  logic              full;
  logic              almostFull;
  logic [ADDR_W:0]   level;
  logic              overflowErr;
  logic              ovfClr;
`ifdef CK2CK_WR_OVF_CNT_EN
  logic [15:0]       ovfCount;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int wb_abs      = 0;
  logic [ADDR_W+DATA_W-1:0] sbq [$];
  logic [ADDR_W+DATA_W-1:0] exp_word;

  ck2ck_fifo_wr_ctrl dut (
    .ckFast        (ckFast),
    .arstFast      (arstFast),
    .pushValid     (pushValid),
    .pushData      (pushData),
    .pushReady     (pushReady),
    .memWrEna      (memWrEna),
    .memWrAddr     (memWrAddr),
    .memWrData     (memWrData),
    .wrPtrGray     (wrPtrGray),
    .rdPtrGrayAsync(rdPtrGrayAsync),
    .full          (full),
    .almostFull    (almostFull),
    .level         (level),
`ifdef CK2CK_WR_OVF_CNT_EN
    .ovfClr        (ovfClr),
    .ovfCount      (ovfCount),
`endif
    .overflowErr   (overflowErr)
  );

  always #5 ckFast = ~ckFast;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic cyc();
    @(posedge ckFast);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    pushValid = 1'b1;
    pushData  = d;
    sbq.push_back({4'(wb_abs), d});
    wb_abs++;
  endtask

  // Every storage write must match the oldest expected word.
  always @(negedge ckFast) begin
    if (memWrEna === 1'b1) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", memWrAddr, memWrData);
      end else begin
        exp_word = sbq.pop_front();
        if ({memWrAddr, memWrData} !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   memWrAddr, memWrData, exp_word[11:8], exp_word[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic test_reset();
    arstFast = 1'b1; pushValid = 1'b0; pushData = '0; rdPtrGrayAsync = '0; ovfClr = 1'b0;
    repeat (3) cyc();
    vectors++;
    if ({pushReady, full, almostFull, overflowErr, memWrEna} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, required 00000", {pushReady, full, almostFull, overflowErr, memWrEna});
    end
    vectors++;
    if (level !== 5'd0 || wrPtrGray !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ptrs: got level=%0d gray=%b, required 0/00000", level, wrPtrGray);
    end
`ifdef CK2CK_WR_OVF_CNT_EN
    vectors++;
    if (ovfCount !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ovfcount: got %0d, required 0", ovfCount);
    end
`endif
  endtask

  task automatic test_init();
    pushValid = 1'b1;
    pushData  = 8'hAA;
    arstFast  = 1'b0;
    wb_abs    = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pushReady !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL init_ready[%0d]: got %b, required %b", i, pushReady, (i == 3));
      end
      if (i == 3) pushValid = 1'b0;
      else cyc();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      push_word(8'(i));
      cyc();
      vectors++;
      if (level !== 5'(i + 1)) begin
        miscompares++;
        $display("[TB] FAIL fill_level[%0d]: got %0d, required %0d", i, level, i + 1);
      end
      vectors++;
      if (almostFull !== (i + 1 >= 12) || full !== (i == 15)) begin
        miscompares++;
        $display("[TB] FAIL fill_flags[%0d]: got afull=%b full=%b, required %b/%b",
                 i, almostFull, full, (i + 1 >= 12), (i == 15));
      end
    end
    pushValid = 1'b0;
    vectors++;
    if (wrPtrGray !== 5'b11000 || pushReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_gray: got gray=%b ready=%b, required 11000/0", wrPtrGray, pushReady);
    end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    pushValid = 1'b1;
    pushData  = 8'hEE;
    repeat (3) begin
      cyc();
      if (overflowErr === 1'b1) pulses++;
    end
    pushValid = 1'b0;
    cyc();
    vectors++;
    if (pulses != 3 || overflowErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_pulses: got %0d pulses, err now %b, required 3/0", pulses, overflowErr);
    end
    vectors++;
    if (wrPtrGray !== 5'b11000 || level !== 5'd16 || full !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_hold: got gray=%b level=%0d full=%b, required 11000/16/1", wrPtrGray, level, full);
    end
`ifdef CK2CK_WR_OVF_CNT_EN
    vectors++;
    if (ovfCount !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL ovf_count: got %0d, required 3", ovfCount);
    end
    ovfClr = 1'b1;
    cyc();
    ovfClr = 1'b0;
    vectors++;
    if (ovfCount !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got %0d, required 0", ovfCount);
    end
`endif
  endtask

  task automatic test_drain_one();
    rdPtrGrayAsync = gray5(1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      vectors++;
      if (full !== (i < 3)) begin
        miscompares++;
        $display("[TB] FAIL drain_full[edge %0d]: got %b, required %b", i, full, (i < 3));
      end
    end
    vectors++;
    if (level !== 5'd15 || pushReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL drain_level: got level=%0d ready=%b, required 15/1", level, pushReady);
    end
    push_word(8'h55);
    cyc();
    pushValid = 1'b0;
    vectors++;
    if (full !== 1'b1 || level !== 5'd16) begin
      miscompares++;
      $display("[TB] FAIL refill: got full=%b level=%0d, required 1/16", full, level);
    end
  endtask

  task automatic test_stream();
    int base;
    rdPtrGrayAsync = gray5(wb_abs);
    repeat (4) cyc();
    vectors++;
    if (level !== 5'd0 || full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL empty: got level=%0d full=%b, required 0/0", level, full);
    end
    base = wb_abs;
    for (int k = 0; k < 40; k++) begin
      rdPtrGrayAsync = gray5((k >= 4) ? wb_abs - 4 : base);
      push_word(8'(8'h80 + k));
      cyc();
      vectors++;
      if (full !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stream_full[%0d]: got %b, required 0", k, full);
      end
      if (k >= 4) begin
        vectors++;
        if (level < 5'd4 || level > 5'd7) begin
          miscompares++;
          $display("[TB] FAIL stream_level[%0d]: got %0d, required 4..7", k, level);
        end
      end
    end
    pushValid = 1'b0;
    rdPtrGrayAsync = gray5(wb_abs - 4);
    repeat (4) cyc();
    vectors++;
    if (level !== 5'd4 || almostFull !== 1'b0 || wrPtrGray !== gray5(wb_abs)) begin
      miscompares++;
      $display("[TB] FAIL stream_settle: got level=%0d afull=%b gray=%b, required 4/0/%b",
               level, almostFull, wrPtrGray, gray5(wb_abs));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      push_word(8'(8'hC0 + i));
      cyc();
    end
    vectors++;
    if (level !== 5'd9) begin
      miscompares++;
      $display("[TB] FAIL mid_level: got %0d, required 9", level);
    end
    arstFast = 1'b1;
    pushValid = 1'b1;
    rdPtrGrayAsync = '0;
    #1;
    vectors++;
    if ({pushReady, full, almostFull, overflowErr, memWrEna} !== 5'b0 || level !== 5'd0 || wrPtrGray !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got flags=%b level=%0d gray=%b, required 00000/0/00000",
               {pushReady, full, almostFull, overflowErr, memWrEna}, level, wrPtrGray);
    end
    pushValid = 1'b0;
    repeat (2) cyc();
    test_init();
    push_word(8'h77);
    cyc();
    pushValid = 1'b0;
    vectors++;
    if (wrPtrGray !== 5'b00001 || level !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL restart: got gray=%b level=%0d, required 00001/1", wrPtrGray, level);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_fill();
    test_overflow();
    test_drain_one();
    test_stream();
    test_reset_mid();
    repeat (2) cyc();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_leftover: got %0d pending writes, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
